// File: rtl/chip8_keypad_scanner.sv
// chip8_keypad_scanner: parametrised active-low matrix keypad scanner.
//
// Each column is driven low in turn. After a settle window the active-low
// rows are sampled into a raw key map. Once per full scan every key is
// debounced against its stable value. Debounced edges are queued in a pending
// mask and drained one at a time through a valid/ready event slot.
//
// Optional build macro: CHIP8_KEYPAD_SYNC_EN
//   defined   - row_vals passes through a two-flop synchronizer (reset to all
//               ones), and the settle window grows by two cycles so that
//               SAMPLE sees synchronized data for the driven column.
//   undefined - row_vals is sampled directly.
//
// Scan FSM states:
//   state    | meaning
//   S_DRIVE  | register the active-low drive for column col_idx_q
//   S_WAIT   | settle window, down-counter wait_cnt_q to terminal count 0
//   S_SAMPLE | capture rows into raw bits of column col_idx_q, advance column
module chip8_keypad_scanner #(
  parameter int NUM_ROWS       = 4,
  parameter int NUM_COLS       = 4,
  parameter int SETTLE_CYCLES  = 2,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [NUM_ROWS-1:0]          row_vals,
  output logic [NUM_COLS-1:0]          col_vals,
  output logic [NUM_ROWS*NUM_COLS-1:0] key_pressed_out,
  output logic                         scan_done_out,
  output logic                         event_valid_out,
  input  logic                         event_ready_in,
  output logic [((NUM_ROWS*NUM_COLS) > 1 ? $clog2(NUM_ROWS*NUM_COLS) : 1)-1:0] event_key_out,
  output logic                         event_press_out
);

  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;
  localparam int KEY_W    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int COL_W    = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
`ifdef CHIP8_KEYPAD_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam int WAIT_LEN = SETTLE_CYCLES + SYNC_LAT;
  localparam int WAIT_W   = (WAIT_LEN > 1) ? $clog2(WAIT_LEN) : 1;
  localparam int DB_W     = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(NUM_COLS - 1);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'((WAIT_LEN > 0) ? (WAIT_LEN - 1) : 0);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_SCANS - 1);

  typedef enum logic [1:0] {
    S_DRIVE  = 2'd0,
    S_WAIT   = 2'd1,
    S_SAMPLE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [COL_W-1:0]      col_idx_q, col_idx_d;
  logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [NUM_COLS-1:0]   col_vals_q, col_vals_d;
  logic [NUM_KEYS-1:0]   raw_q, raw_d;
  logic                  scan_last;
  logic                  scan_done_q;

  logic [NUM_KEYS-1:0]   stable_q, stable_d;
  logic [DB_W-1:0]       cnt_q [NUM_KEYS];
  logic [DB_W-1:0]       cnt_d [NUM_KEYS];
  logic [NUM_KEYS-1:0]   change;

  logic [NUM_KEYS-1:0]   pending_q, pending_d;
  logic [NUM_KEYS-1:0]   pick_oh;
  logic [NUM_KEYS-1:0]   load_oh;
  logic [KEY_W-1:0]      pick_idx;
  logic                  pick_found;
  logic                  slot_free;
  logic                  ev_valid_q, ev_valid_d;
  logic [KEY_W-1:0]      ev_key_q, ev_key_d;
  logic                  ev_press_q, ev_press_d;

  logic [NUM_ROWS-1:0]   row_smp;

`ifdef CHIP8_KEYPAD_SYNC_EN
  logic [NUM_ROWS-1:0]   row_meta_q;
  logic [NUM_ROWS-1:0]   row_sync_q;

  // Two-flop synchronizer; idle level (all ones) means no key pressed.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
    end else begin
      row_meta_q <= row_vals;
      row_sync_q <= row_meta_q;
    end
  end

  assign row_smp = row_sync_q;
`else
  assign row_smp = row_vals;
`endif

  // Scan FSM, column drive, raw map and scan-end pulse registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= S_DRIVE;
      col_idx_q   <= '0;
      wait_cnt_q  <= '0;
      col_vals_q  <= '1;
      raw_q       <= '0;
      scan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      wait_cnt_q  <= wait_cnt_d;
      col_vals_q  <= col_vals_d;
      raw_q       <= raw_d;
      scan_done_q <= scan_last;
    end
  end

  // Scan FSM next state: drive, settle, sample, then move to the next column.
  always_comb begin
    state_d    = state_q;
    col_idx_d  = col_idx_q;
    wait_cnt_d = wait_cnt_q;
    col_vals_d = col_vals_q;
    raw_d      = raw_q;
    scan_last  = 1'b0;
    case (state_q)
      S_DRIVE: begin
        for (int c = 0; c < NUM_COLS; c++) begin
          col_vals_d[c] = (COL_W'(c) != col_idx_q);
        end
        wait_cnt_d = WAIT_INIT;
        state_d    = (WAIT_LEN == 0) ? S_SAMPLE : S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt_q == '0) begin
          state_d = S_SAMPLE;
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        end
      end
      S_SAMPLE: begin
        for (int r = 0; r < NUM_ROWS; r++) begin
          for (int c = 0; c < NUM_COLS; c++) begin
            if (COL_W'(c) == col_idx_q) begin
              raw_d[r*NUM_COLS + c] = ~row_smp[r];
            end
          end
        end
        state_d = S_DRIVE;
        if (col_idx_q == LAST_COL) begin
          col_idx_d = '0;
          scan_last = 1'b1;
        end else begin
          col_idx_d = col_idx_q + COL_W'(1);
        end
      end
      default: begin
        state_d = S_DRIVE;
      end
    endcase
  end

  // Whole-scan debounce: a key flips after DEBOUNCE_SCANS disagreeing scans in a row.
  always_comb begin
    stable_d = stable_q;
    change   = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      cnt_d[k] = cnt_q[k];
    end
    if (scan_last) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (raw_d[k] == stable_q[k]) begin
          cnt_d[k] = '0;
        end else if (cnt_q[k] == DB_LAST) begin
          stable_d[k] = ~stable_q[k];
          cnt_d[k]    = '0;
          change[k]   = 1'b1;
        end else begin
          cnt_d[k] = cnt_q[k] + DB_W'(1);
        end
      end
    end
  end

  // Debounced map and per-key disagreement counters.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stable_q <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      for (int k = 0; k < NUM_KEYS; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  // Lowest-index pending key; descending loop so the lowest set bit wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_oh    = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (pending_q[k]) begin
        pick_found = 1'b1;
        pick_idx   = KEY_W'(k);
        pick_oh    = '0;
        pick_oh[k] = 1'b1;
      end
    end
  end

  // Event slot refill and pending-mask bookkeeping.
  always_comb begin
    slot_free  = !ev_valid_q || event_ready_in;
    ev_valid_d = ev_valid_q;
    ev_key_d   = ev_key_q;
    ev_press_d = ev_press_q;
    load_oh    = '0;
    if (slot_free) begin
      ev_valid_d = pick_found;
      if (pick_found) begin
        load_oh    = pick_oh;
        ev_key_d   = pick_idx;
        // Post-update stable value, so a same-cycle flip is reported correctly.
        ev_press_d = |(stable_d & pick_oh);
      end
    end
    // A second flip before emission cancels the first; a flip of the key
    // sitting in the slot re-arms its pending bit.
    pending_d = pending_q ^ change ^ load_oh;
  end

  // Event slot and pending mask registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pending_q  <= '0;
      ev_valid_q <= 1'b0;
      ev_key_q   <= '0;
      ev_press_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      ev_valid_q <= ev_valid_d;
      ev_key_q   <= ev_key_d;
      ev_press_q <= ev_press_d;
    end
  end

  assign col_vals        = col_vals_q;
  assign key_pressed_out = stable_q;
  assign scan_done_out   = scan_done_q;
  assign event_valid_out = ev_valid_q;
  assign event_key_out   = ev_key_q;
  assign event_press_out = ev_press_q;

endmodule

// File: tb/tb_chip8_keypad_scanner.sv
// Directed bench for chip8_keypad_scanner at default parameters (4x4, settle 2,
// debounce 3). A small key-matrix model pulls rows low for held keys on the
// driven column. Inputs change and outputs are checked on the falling edge.
module tb_chip8_keypad_scanner;

  logic        clk;
  logic        rst;
  logic [3:0]  row_vals;
  logic [3:0]  col_vals;
  logic [15:0] key_pressed;
  logic        scan_done;
  logic        ev_valid;
  logic        ev_ready;
  logic [3:0]  ev_key;
  logic        ev_press;

  logic [15:0] keys;
  logic [15:0] exp_kp;
  logic [3:0]  exp_col;
  int          checks;
  int          errors;

  chip8_keypad_scanner dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .row_vals        (row_vals),
    .col_vals        (col_vals),
    .key_pressed_out (key_pressed),
    .scan_done_out   (scan_done),
    .event_valid_out (ev_valid),
    .event_ready_in  (ev_ready),
    .event_key_out   (ev_key),
    .event_press_out (ev_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key matrix: a held key shorts its row to its column when that column is low.
  always_comb begin
    row_vals = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4 + c] && !col_vals[c]) row_vals[r] = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  task automatic chk_ev(input string tag, input logic v, input logic [3:0] k, input logic p);
    chk({tag, "_valid"}, 32'(ev_valid), 32'(v));
    if (v) begin
      chk({tag, "_key"}, 32'(ev_key), 32'(k));
      chk({tag, "_press"}, 32'(ev_press), 32'(p));
    end
  endtask

  // Advance to the next falling edge where scan_done is high (bounded).
  task automatic wait_sd();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (scan_done !== 1'b1 && n < 20);
    checks++;
    assert (scan_done === 1'b1)
      else begin
        errors++;
        $error("FAIL scan_done_timeout: observed %0b expected 1", scan_done);
      end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    keys     = '0;
    ev_ready = 1'b1;
    exp_kp   = '0;

    repeat (3) @(negedge clk);
    chk("rst_col", 32'(col_vals), 32'hF);
    chk("rst_kp", 32'(key_pressed), 32'h0);
    chk("rst_sd", 32'(scan_done), 32'h0);
    chk("rst_valid", 32'(ev_valid), 32'h0);
    chk("rst_key", 32'(ev_key), 32'h0);
    chk("rst_press", 32'(ev_press), 32'h0);
    rst = 1'b0;

    // Idle scan: each column held 4 cycles, scan_done every 16, no events.
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      exp_col = ~(4'b0001 << (((i - 1) / 4) % 4));
      chk("idle_col", 32'(col_vals), 32'(exp_col));
      chk("idle_sd", 32'(scan_done), (i % 16 == 0) ? 32'h1 : 32'h0);
      chk("idle_valid", 32'(ev_valid), 32'h0);
    end
    chk("idle_kp", 32'(key_pressed), 32'h0);

    // Key 9 (row 2, col 1) press, then release.
    keys[9] = 1'b1;
    wait_sd();
    chk("k9_sd1_kp", 32'(key_pressed), 32'h0);
    wait_sd();
    chk("k9_sd2_kp", 32'(key_pressed), 32'h0);
    wait_sd();
    exp_kp = 16'h0200;
    chk("k9_sd3_kp", 32'(key_pressed), 32'(exp_kp));
    chk("k9_sd3_valid", 32'(ev_valid), 32'h0);
    keys[9] = 1'b0;
    @(negedge clk);
    chk_ev("k9_press", 1'b1, 4'd9, 1'b1);
    @(negedge clk);
    chk_ev("k9_press_done", 1'b0, 4'd0, 1'b0);
    wait_sd();
    wait_sd();
    chk("k9_rel_sd2_kp", 32'(key_pressed), 32'(exp_kp));
    wait_sd();
    exp_kp = 16'h0000;
    chk("k9_rel_kp", 32'(key_pressed), 32'(exp_kp));
    @(negedge clk);
    chk_ev("k9_release", 1'b1, 4'd9, 1'b0);
    @(negedge clk);
    chk_ev("k9_rel_done", 1'b0, 4'd0, 1'b0);

    // Bounce on key 5: 2 scans pressed, 1 released, then 3 pressed.
    wait_sd();
    keys[5] = 1'b1;
    wait_sd();
    wait_sd();
    keys[5] = 1'b0;
    wait_sd();
    chk("b5_sd3_kp", 32'(key_pressed), 32'h0);
    keys[5] = 1'b1;
    wait_sd();
    chk("b5_sd4_kp", 32'(key_pressed), 32'h0);
    wait_sd();
    chk("b5_sd5_kp", 32'(key_pressed), 32'h0);
    @(negedge clk);
    chk_ev("b5_no_event", 1'b0, 4'd0, 1'b0);
    wait_sd();
    exp_kp = 16'h0020;
    chk("b5_sd6_kp", 32'(key_pressed), 32'(exp_kp));
    @(negedge clk);
    chk_ev("b5_press", 1'b1, 4'd5, 1'b1);
    @(negedge clk);
    chk_ev("b5_single", 1'b0, 4'd0, 1'b0);

    // Keys 3 and 12 debounce in the same scan while the consumer stalls.
    wait_sd();
    ev_ready = 1'b0;
    keys[3]  = 1'b1;
    keys[12] = 1'b1;
    wait_sd();
    wait_sd();
    wait_sd();
    exp_kp = 16'h1028;
    chk("k3k12_kp", 32'(key_pressed), 32'(exp_kp));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_ev("k3_hold", 1'b1, 4'd3, 1'b1);
    end
    ev_ready = 1'b1;
    @(negedge clk);
    chk_ev("k12_next", 1'b1, 4'd12, 1'b1);
    @(negedge clk);
    chk_ev("k12_drained", 1'b0, 4'd0, 1'b0);
    ev_ready = 1'b0;

    // Key 7 press held in the slot while key 7 releases and debounces.
    wait_sd();
    keys[7] = 1'b1;
    wait_sd();
    wait_sd();
    wait_sd();
    exp_kp = 16'h10A8;
    chk("k7_kp", 32'(key_pressed), 32'(exp_kp));
    @(negedge clk);
    chk_ev("k7_press", 1'b1, 4'd7, 1'b1);
    keys[7] = 1'b0;
    wait_sd();
    chk_ev("k7_hold1", 1'b1, 4'd7, 1'b1);
    wait_sd();
    chk_ev("k7_hold2", 1'b1, 4'd7, 1'b1);
    wait_sd();
    exp_kp = 16'h1028;
    chk("k7_rel_kp", 32'(key_pressed), 32'(exp_kp));
    chk_ev("k7_hold3", 1'b1, 4'd7, 1'b1);
    ev_ready = 1'b1;
    @(negedge clk);
    chk_ev("k7_release", 1'b1, 4'd7, 1'b0);
    @(negedge clk);
    chk_ev("k7_drained", 1'b0, 4'd0, 1'b0);

    // Reset mid-WAIT with an event outstanding.
    ev_ready = 1'b0;
    wait_sd();
    keys[0] = 1'b1;
    wait_sd();
    wait_sd();
    wait_sd();
    chk("k0_kp", 32'(key_pressed), 32'h1029);
    @(negedge clk);
    chk_ev("k0_pending", 1'b1, 4'd0, 1'b1);
    rst  = 1'b1;
    keys = '0;
    @(negedge clk);
    chk("mid_rst_col", 32'(col_vals), 32'hF);
    chk("mid_rst_kp", 32'(key_pressed), 32'h0);
    chk("mid_rst_sd", 32'(scan_done), 32'h0);
    chk("mid_rst_valid", 32'(ev_valid), 32'h0);
    chk("mid_rst_key", 32'(ev_key), 32'h0);
    chk("mid_rst_press", 32'(ev_press), 32'h0);
    rst      = 1'b0;
    ev_ready = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      exp_col = ~(4'b0001 << (((i - 1) / 4) % 4));
      chk("post_rst_col", 32'(col_vals), 32'(exp_col));
      chk("post_rst_sd", 32'(scan_done), (i % 16 == 0) ? 32'h1 : 32'h0);
      chk("post_rst_valid", 32'(ev_valid), 32'h0);
      chk("post_rst_kp", 32'(key_pressed), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chip8_keypad_scanner.md
Name: chip8_keypad_scanner

Overview:
- Parametrised matrix-keypad scanner; successor to the fixed 4x4 CHIP-8 poller.
- Drives one active-low column at a time, waits a configurable settle time, then samples the active-low rows.
- Debounces every key across whole scans and presents a level map of debounced keys.
- Emits a serialized press/release event stream with valid/ready handshake, for the CHIP-8 core's key-wait instruction (FX0A) and host logging.

Parameters:
- NUM_ROWS, 4, number of row inputs (>=1)
- NUM_COLS, 4, number of column outputs (>=1)
- SETTLE_CYCLES, 2, idle cycles between driving a column and sampling rows (>=0)
- DEBOUNCE_SCANS, 3, consecutive full scans a raw value must differ from debounced value before it flips (>=1)

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset
- row_vals  input  NUM_ROWS  raw rows, active low (0 = pressed key on driven column)
- col_vals  output  NUM_COLS  column drive, active low, exactly one bit 0 while scanning
- key_pressed_out  output  NUM_ROWS*NUM_COLS  debounced map, bit r*NUM_COLS+c = key at row r/col c
- scan_done_out  output  1  one-cycle pulse when a full scan's debounce update commits
- event_valid_out  output  1  event slot occupied
- event_ready_in  input  1  consumer accepts event when high with valid
- event_key_out  output  clog2(NUM_ROWS*NUM_COLS) (min 1)  key index of event
- event_press_out  output  1  1 = press, 0 = release

Behaviour:
- One clock clk_in; rst_in is synchronous, active-high.
- Reset values: col_vals all ones; key_pressed_out, scan_done_out, event_valid_out, event_key_out and event_press_out all 0. Internal column index, debounce counters and pending mask all cleared. First DRIVE for column 0 occurs the cycle after rst_in deasserts.
- Reset mid-scan or with an event outstanding discards everything; no event survives reset.
- FSM per column c: DRIVE (1 cycle), then WAIT (SETTLE_CYCLES cycles; skipped if 0), then SAMPLE (1 cycle).
  - DRIVE: registers col_vals = ~(1<<c).
  - SAMPLE: captures ~row_vals into raw bits {r*NUM_COLS+c}; c advances, wrapping NUM_COLS-1 -> 0.
  - col_vals holds its value from DRIVE until the next DRIVE.
- Scan period = NUM_COLS*(2+SETTLE_CYCLES) cycles. Defaults: 16 cycles; SETTLE_CYCLES=0 gives 8 cycles, matching the legacy poller.
- Scan end, on the cycle after SAMPLE of column NUM_COLS-1: scan_done_out pulses and the debounce update commits, per key k:
  - raw == stable: counter := 0.
  - Otherwise counter+1; if it reaches DEBOUNCE_SCANS, stable[k] flips, counter := 0, change[k] = 1.
  - The scan-end cycle overlaps the next column-0 DRIVE, so scanning never stalls.
- key_pressed_out = stable, updated on the scan-end edge.
- Pending mask update: pending := pending ^ change ^ load, where load is the one-hot of the key moved into the slot this cycle.
  - Two net flips of a key before emission cancel; no spurious event.
- Event slot:
  - When the slot is empty, or accepted this cycle (valid & ready), it loads the lowest-index set pending bit.
  - On load: event_key_out = k, event_press_out = stable[k] as of load (post-update value if same cycle).
  - If no pending bit is set, event_valid_out drops.
  - One-cycle latency from scan-end to event_valid_out when the slot is free.
  - While valid & !ready, event_key_out and event_press_out hold stable.
  - Back-to-back events are possible, one per cycle.
  - No overflow: pending holds at most one outstanding edge per key.
- A key already in the slot that flips again re-sets its pending bit, so the slot emits press then release, strictly alternating per key.

Optional Feature:
- CHIP8_KEYPAD_SYNC_EN defined: two-flop synchronizer on row_vals, reset to all ones. WAIT lengthens to SETTLE_CYCLES+2 so SAMPLE sees synchronized data for the driven column. Scan period = NUM_COLS*(4+SETTLE_CYCLES).
- Undefined: row_vals sampled directly; timing as above.

Test Plan:
- Reset then idle rows all 1s -> col_vals cycles 1110,1101,1011,0111 (defaults), each held 4 cycles; scan_done_out every 16 cycles; key_pressed_out=0; no events.
- Hold key row 2/col 1 (index 9) for 3 full scans, ready=1 -> bit 9 rises at 3rd scan_done; next cycle event valid key=9 press=1 for one cycle. Release for 3 scans -> key=9 press=0.
- Bounce: key 5 pressed 2 scans, released 1, pressed 3 -> single press event, only after 3rd consecutive scan.
- Keys 3 and 12 debounce same scan, ready=0 for 10 cycles -> key=3 press=1 held stable; raise ready -> key 3 then key 12 on consecutive cycles.
- Key 7 press event held with ready=0 while key 7 releases and debounces -> after accept, key=7 press=0 emitted; no lost or duplicated edge.
- Assert rst_in mid-WAIT with event pending -> next cycle all outputs at reset values; scanning restarts at column 0.
